// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding common to the receiver and transmitter,
// plus the default baud divider for a 100 MHz clock at 9600 baud.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      PARITY  = 3'd3,
      STOP    = 3'd4,
      CLEANUP = 3'd5
   } uartState_e;

   localparam int DEFAULT_CLKS_PER_BIT = 100_000_000 / 9_600;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: the serial line into the receiver and the byte/strobe outputs to the consumer.
// The master drives the line and watches the results; the slave is the receiver itself.
interface uart_rx_if;

   logic       rx_serialIn;
   logic [7:0] rxByte;
   logic       rxDone;
   logic       rxActive;
   logic       frameErr;
   logic       parityErr;

   modport master (
      output rx_serialIn,
      input  rxByte, rxDone, rxActive, frameErr, parityErr
   );

   modport slave (
      input  rx_serialIn,
      output rxByte, rxDone, rxActive, frameErr, parityErr
   );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous pad input; both flops reset to RST_VAL.
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, mid-bit sampling. Defining UART_RX_PARITY_EN adds an
// even-parity bit between data and stop; otherwise parityErr is tied low.
module uart_rx
   import uart_pkg::*;
#(
   parameter  int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic     clk,
   input  logic     rst,
   uart_rx_if.slave rxIf
);

   localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic             rxs;
   uartState_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       idx_q;
   logic [7:0]       shift_q;
   logic [7:0]       rxByte_q;
   logic             rxDone_q;
   logic             rxActive_q;
   logic             frameErr_q;
   logic             cntLast;
`ifdef UART_RX_PARITY_EN
   logic             parityErr_q;
   logic             parOk_q;
`endif

   uart_sync2 #(.RST_VAL(1'b1)) syncRx (
      .clk (clk),
      .rst (rst),
      .d_i (rxIf.rx_serialIn),
      .q_o (rxs)
   );

   assign cntLast = (cnt_q == LAST);

   // Status pulses default low every cycle, so any strobe raised at a sample edge lasts exactly one clock.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         rxByte_q   <= '0;
         rxDone_q   <= 1'b0;
         rxActive_q <= 1'b0;
         frameErr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parityErr_q <= 1'b0;
         parOk_q     <= 1'b1;
`endif
      end else begin
         rxDone_q   <= 1'b0;
         frameErr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parityErr_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               idx_q <= '0;
               if (!rxs) begin
                  state_q    <= START;
                  rxActive_q <= 1'b1;
               end
            end
            START: begin
               if (cnt_q == HALF) begin
                  cnt_q <= '0;
                  if (!rxs) begin
                     state_q <= DATA;
                  end else begin
                     state_q    <= IDLE;
                     rxActive_q <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DATA: begin
               if (cntLast) begin
                  cnt_q          <= '0;
                  shift_q[idx_q] <= rxs;
                  if (idx_q == 3'd7) begin
                     idx_q <= '0;
`ifdef UART_RX_PARITY_EN
                     state_q <= PARITY;
`else
                     state_q <= STOP;
`endif
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cntLast) begin
                  cnt_q   <= '0;
                  parOk_q <= ~(^{shift_q, rxs});
                  state_q <= STOP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
`endif
            STOP: begin
               if (cntLast) begin
                  cnt_q      <= '0;
                  state_q    <= CLEANUP;
                  rxActive_q <= 1'b0;
                  if (!rxs) begin
                     frameErr_q <= 1'b1;
                  end
`ifdef UART_RX_PARITY_EN
                  if (!parOk_q) begin
                     parityErr_q <= 1'b1;
                  end else if (rxs) begin
                     rxByte_q <= shift_q;
                     rxDone_q <= 1'b1;
                  end
`else
                  if (rxs) begin
                     rxByte_q <= shift_q;
                     rxDone_q <= 1'b1;
                  end
`endif
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            // Wait for the line to return high so a held-low break cannot look like a new start bit.
            CLEANUP: begin
               if (rxs) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q    <= IDLE;
               rxActive_q <= 1'b0;
            end
         endcase
      end
   end

   assign rxIf.rxByte   = rxByte_q;
   assign rxIf.rxDone   = rxDone_q;
   assign rxIf.rxActive = rxActive_q;
   assign rxIf.frameErr = frameErr_q;
`ifdef UART_RX_PARITY_EN
   assign rxIf.parityErr = parityErr_q;
`else
   assign rxIf.parityErr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: table vectors, hand-written corner
// sequences and randomized frames scored against a frame-level reference model.
module tb_uart_rx;

   localparam int CPB = 16;

   logic clk = 1'b0;
   logic rst;

   uart_rx_if rxIf ();

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk  (clk),
      .rst  (rst),
      .rxIf (rxIf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int doneCycles = 0;
   int ferrCycles = 0;
   int perrCycles = 0;
   int activeCycles = 0;
   logic [7:0] gotQ[$];

   int d0, f0, p0, a0;

   // Monitor: count high cycles of each status output and capture the byte at every done strobe.
   always @(negedge clk) begin
      if (rxIf.rxDone) begin
         doneCycles++;
         gotQ.push_back(rxIf.rxByte);
      end
      if (rxIf.frameErr)  ferrCycles++;
      if (rxIf.parityErr) perrCycles++;
      if (rxIf.rxActive)  activeCycles++;
   end

   // Watchdog so the run always ends even if something stalls.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected run to complete");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
      end
   endtask

   task automatic snap();
      d0 = doneCycles;
      f0 = ferrCycles;
      p0 = perrCycles;
      a0 = activeCycles;
      gotQ.delete();
   endtask

   task automatic driveBit(input logic b);
      rxIf.rx_serialIn = b;
      repeat (CPB) @(negedge clk);
   endtask

   // One frame on the line, then gap idle-high cycles (gap 0 leaves the line at the stop value).
   task automatic applyStimulus(input logic [7:0] data, input bit stopGood, input bit parGood, input int gap);
      driveBit(1'b0);
      for (int i = 0; i < 8; i++) driveBit(data[i]);
`ifdef UART_RX_PARITY_EN
      driveBit(parGood ? ^data : ~(^data));
`endif
      driveBit(stopGood);
      if (gap > 0) begin
         rxIf.rx_serialIn = 1'b1;
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic checkFrame(input string name, input int expDone, input int expFerr, input logic [7:0] expByte);
      #1;
      checkOutput({name, " doneCycles"}, doneCycles - d0, expDone);
      checkOutput({name, " ferrCycles"}, ferrCycles - f0, expFerr);
      checkOutput({name, " rxByte"}, int'(rxIf.rxByte), int'(expByte));
      if (expDone == 1) begin
         if (gotQ.size() > 0) checkOutput({name, " byteAtDone"}, int'(gotQ.pop_front()), int'(expByte));
         else checkOutput({name, " byteAtDone"}, -1, int'(expByte));
      end
   endtask

   typedef struct {
      logic [7:0] data;
      bit         stopGood;
      int         gap;
      int         expDone;
      int         expFerr;
      logic [7:0] expByte;
   } vec_t;

   vec_t vecs[6];

   logic [7:0] lastGood;

   initial begin
      vecs[0] = '{8'hA5, 1'b1, 20, 1, 0, 8'hA5};
      vecs[1] = '{8'h3C, 1'b1, 20, 1, 0, 8'h3C};
      vecs[2] = '{8'h81, 1'b0, 20, 0, 1, 8'h3C};
      vecs[3] = '{8'h00, 1'b1,  5, 1, 0, 8'h00};
      vecs[4] = '{8'hFF, 1'b1, 20, 1, 0, 8'hFF};
      vecs[5] = '{8'h6E, 1'b0, 20, 0, 1, 8'hFF};

      rxIf.rx_serialIn = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset rxByte",    int'(rxIf.rxByte),    0);
      checkOutput("reset rxDone",    int'(rxIf.rxDone),    0);
      checkOutput("reset rxActive",  int'(rxIf.rxActive),  0);
      checkOutput("reset frameErr",  int'(rxIf.frameErr),  0);
      checkOutput("reset parityErr", int'(rxIf.parityErr), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // Table vectors; the first one also measures how long rxActive stays high.
      for (int i = 0; i < 6; i++) begin
         snap();
         applyStimulus(vecs[i].data, vecs[i].stopGood, 1'b1, vecs[i].gap);
         checkFrame($sformatf("vec%0d", i), vecs[i].expDone, vecs[i].expFerr, vecs[i].expByte);
         if (i == 0) begin
            checkOutput("vec0 activeInRange", int'((activeCycles - a0) >= 144 && (activeCycles - a0) <= 170), 1);
         end
      end

      // Short glitch: START must abort at the half-bit sample.
      snap();
      rxIf.rx_serialIn = 1'b0;
      repeat (5) @(negedge clk);
      rxIf.rx_serialIn = 1'b1;
      repeat (30) @(negedge clk);
      checkFrame("glitch", 0, 0, 8'hFF);
      checkOutput("glitch activeShort", int'((activeCycles - a0) >= 1 && (activeCycles - a0) <= 8), 1);

      // Break: bad stop then line held low; no retrigger until it rises.
      snap();
      applyStimulus(8'h3C, 1'b1, 1'b1, 10);
      checkFrame("break good", 1, 0, 8'h3C);
      snap();
      applyStimulus(8'h81, 1'b0, 1'b1, 0);
      #1;
      a0 = activeCycles;
      repeat (40) @(negedge clk);
      checkFrame("break held", 0, 1, 8'h3C);
      checkOutput("break noRestart", activeCycles - a0, 0);
      rxIf.rx_serialIn = 1'b1;
      repeat (20) @(negedge clk);
      snap();
      applyStimulus(8'h96, 1'b1, 1'b1, 10);
      checkFrame("break recover", 1, 0, 8'h96);

      // Back-to-back frames with no idle gap.
      snap();
      applyStimulus(8'h00, 1'b1, 1'b1, 0);
      applyStimulus(8'hFF, 1'b1, 1'b1, 20);
      #1;
      checkOutput("b2b doneCycles", doneCycles - d0, 2);
      checkOutput("b2b count", gotQ.size(), 2);
      if (gotQ.size() == 2) begin
         checkOutput("b2b first",  int'(gotQ[0]), 8'h00);
         checkOutput("b2b second", int'(gotQ[1]), 8'hFF);
      end

      // Randomized frames against the frame-level model.
      lastGood = 8'hFF;
      for (int n = 0; n < 12; n++) begin
         logic [7:0] d;
         bit good;
         int gap;
         d    = 8'($urandom);
         good = ($urandom_range(0, 3) != 0);
         gap  = good ? $urandom_range(0, 30) : $urandom_range(2, 30);
         if (good) lastGood = d;
         snap();
         applyStimulus(d, good, 1'b1, gap);
         checkFrame($sformatf("rand%0d", n), good ? 1 : 0, good ? 0 : 1, lastGood);
      end
      rxIf.rx_serialIn = 1'b1;
      repeat (20) @(negedge clk);

      // Reset in the middle of data bit 4 of 0x55.
      snap();
      applyStimulus(8'h5A, 1'b1, 1'b1, 10);
      checkFrame("preReset", 1, 0, 8'h5A);
      snap();
      driveBit(1'b0);
      for (int i = 0; i < 4; i++) driveBit(1'(8'h55 >> i));
      rxIf.rx_serialIn = 1'b1;
      repeat (CPB / 2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("midReset rxByte",    int'(rxIf.rxByte),   0);
      checkOutput("midReset rxDone",    int'(rxIf.rxDone),   0);
      checkOutput("midReset rxActive",  int'(rxIf.rxActive), 0);
      checkOutput("midReset frameErr",  int'(rxIf.frameErr), 0);
      repeat (30) @(negedge clk);
      checkFrame("midReset aborted", 0, 0, 8'h00);
      snap();
      applyStimulus(8'hC3, 1'b1, 1'b1, 20);
      checkFrame("afterReset", 1, 0, 8'hC3);

`ifdef UART_RX_PARITY_EN
      snap();
      applyStimulus(8'h03, 1'b1, 1'b0, 20);
      checkFrame("parity bad", 0, 0, 8'hC3);
      checkOutput("parity bad perr", perrCycles - p0, 1);
      snap();
      applyStimulus(8'h03, 1'b1, 1'b1, 20);
      checkFrame("parity good", 1, 0, 8'h03);
      checkOutput("parity good perr", perrCycles - p0, 0);
      checkOutput("parityErr total", perrCycles, 1);
`else
      checkOutput("parityErr total", perrCycles, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
